// File: rtl/rf_write_logger.sv
// Register-file write observer: timestamps architectural writes into a
// FWFT FIFO and keeps a readable shadow copy of all 32 registers.
module rf_write_logger #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               rf_we,
  input  logic [4:0]         rf_waddr,
  input  logic [31:0]        rf_wdata,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_addr,
  output logic [31:0]        out_data,
  output logic [STAMP_W-1:0] out_stamp,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  output logic [7:0]         drop_count,
  input  logic [4:0]         sh_raddr,
  output logic [31:0]        sh_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_q, drop_d;
  logic [STAMP_W-1:0] stamp_q;

  logic [4:0]         mem_addr  [DEPTH];
  logic [31:0]        mem_data  [DEPTH];
  logic [STAMP_W-1:0] mem_stamp [DEPTH];
  logic [31:0]        sh_q      [32];

  logic cap, full, pop, push, drop;

  assign cap  = rf_we && (rf_waddr != 5'd0);
  assign full = (cnt_q == CNT_W'(DEPTH));
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts a capture when the head leaves this cycle
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      drop_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case (1'b1)
        push && !pop: cnt_d = cnt_q + CNT_W'(1);
        pop && !push: cnt_d = cnt_q - CNT_W'(1);
        default:      cnt_d = cnt_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      stamp_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      stamp_q <= stamp_q + STAMP_W'(1);
    end
  end

  // Storage needs no reset: outputs are gated by occupancy
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_addr[wptr_q]  <= rf_waddr;
      mem_data[wptr_q]  <= rf_wdata;
      mem_stamp[wptr_q] <= stamp_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) sh_q[i] <= '0;
    end else if (cap) begin
      sh_q[rf_waddr] <= rf_wdata;
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign out_addr   = out_valid ? mem_addr[rptr_q]  : '0;
  assign out_data   = out_valid ? mem_data[rptr_q]  : '0;
  assign out_stamp  = out_valid ? mem_stamp[rptr_q] : '0;
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign sh_rdata   = (sh_raddr == 5'd0) ? 32'd0 : sh_q[sh_raddr];

endmodule

// File: doc/rf_write_logger.md
Name: rf_write_logger

Overview:
- Passive observer on the processor's register-file write port, sitting directly downstream of the skeleton's regfile write interface.
- Timestamps every architectural write and buffers it in a FIFO for a drain consumer (bench checker or trace UART).
- Keeps a shadow copy of all 32 registers that can be read back on a side port.
- Does not affect processor execution; replaces ad-hoc bench shadow logic with synthesizable RTL.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, at least 2.
- STAMP_W, 16, width of the free-running cycle stamp.
- CNT_W, 5, occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clock  in  1  regfile clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rf_we  in  1  regfile write enable tap.
- rf_waddr  in  5  regfile write address tap.
- rf_wdata  in  32  regfile write data tap.
- clear  in  1  synchronous flush of the FIFO and error state.
- out_valid  out  1  FIFO head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_addr  out  5  head entry register number.
- out_data  out  32  head entry write data.
- out_stamp  out  STAMP_W  head entry cycle stamp.
- count  out  CNT_W  current FIFO occupancy.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.
- drop_count  out  8  number of dropped writes; saturates at 255.
- sh_raddr  in  5  shadow file read address.
- sh_rdata  out  32  shadow file read data (combinational).

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO empty, count=0, out_valid=0.
  - overflow=0, drop_count=0, stamp=0.
  - All shadow registers 0.
  - out_addr/out_data/out_stamp=0 while empty.
- Stamp:
  - Increments by 1 every clock while reset_n is high.
  - Wraps from 2^STAMP_W-1 to 0.
  - Unaffected by clear.
- Capture event: rf_we=1 and rf_waddr!=0 at a rising clock edge.
  - Writes to r0 are ignored entirely: no FIFO push, no shadow update.
- Entry contents: {stamp value in that cycle, rf_waddr, rf_wdata}.
  - A write in the first cycle after reset release carries stamp 0.
- Shadow file:
  - On a capture event, shadow[rf_waddr] <= rf_wdata. This happens regardless of FIFO state and regardless of clear.
  - sh_rdata = shadow[sh_raddr] combinationally; address 0 always reads 0.
  - A read of the address being written in the same cycle returns the old value; the new value is visible the next cycle.
- FIFO:
  - First-word-fall-through: out_* present the head whenever out_valid=1.
  - Pop occurs when out_valid and out_ready are both 1 at a clock edge.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - When full with no pop, an incoming capture is dropped: overflow is set (sticky) and drop_count increments, saturating at 255.
  - When full with a simultaneous pop, the incoming capture is accepted; no drop.
  - Pop when empty has no effect (out_ready is ignored).
  - Read and write pointers wrap modulo DEPTH.
- Latency: a capture at edge N gives out_valid=1 after edge N if the FIFO was empty (visible in cycle N+1).
- Clear (synchronous, highest priority):
  - FIFO emptied, count=0, overflow=0, drop_count=0.
  - Any push or pop in the same cycle is discarded; the discarded push is not counted as a drop.
  - Shadow file and stamp are unaffected.
- Reset asserted mid-operation: all state is lost immediately; no partial entry may remain.
- out_valid is deasserted asynchronously with reset_n.

Test Plan:
- Reset, release, then write r5=0xDEADBEEF at the first post-reset edge -> out_valid=1, out_addr=5, out_data=0xDEADBEEF, out_stamp=0, count=1; sh_raddr=5 reads 0xDEADBEEF the next cycle.
- Write r0=0x12345678 -> count stays 0, out_valid=0, sh_rdata for address 0 = 0.
- out_ready=0, 17 consecutive writes r1..r17 with DEPTH=16 -> count=16, overflow=1, drop_count=1; draining yields r1..r16 in order with stamps incrementing by 1; shadow r17 still updated.
- FIFO full with out_ready=1 and a write in the same cycle -> count stays 16, no drop, head advances, and the new entry appears at the tail.
- clear asserted in the same cycle as a write r3=0x5 -> count=0, overflow=0, drop_count=0, entry not logged; shadow r3=0x5.
- reset_n pulsed low mid-drain with 4 entries queued -> out_valid=0 immediately, count=0, all shadow registers read 0, stamp restarts at 0.
